uart_rx_fifo: RTL and testbench

Receive buffer directly downstream of the UART receiver. It captures each byte presented on P_DATA when data_valid pulses and stores it in a first-word-fall-through FIFO. A consumer drains the FIFO through a valid/ready handshake. The block reports occupancy, a programmable almost-full level, and a sticky overflow flag, so bytes are not lost silently when the consumer stalls.

---
 rtl/uart_rx_fifo_mem.sv | 36 +++
 rtl/uart_rx_fifo.sv | 117 +++++++++++
 tb/tb_uart_rx_fifo.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_mem.sv
// uart_rx_fifo_mem: DEPTH x DATA_WIDTH register file for the UART receive FIFO.
//
// Ports:
//   clk   - system clock
//   we    - write enable, sampled on the rising edge of clk
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - combinational read data, mem[raddr]
//
// The storage is not reset. A read of the address being written in the same
// cycle returns the old contents, because the write lands on the clock edge.
module uart_rx_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive buffer behind the UART receiver.
//
// Ports:
//   CLK         - system clock (same clock as the receiver)
//   RST         - synchronous, active-high reset
//   P_DATA      - received byte from the receiver
//   data_valid  - one-cycle strobe, P_DATA valid in that cycle
//   flush       - synchronous clear of the FIFO contents
//   clr_ovf     - clears the sticky overflow flag
//   af_level    - almost-full threshold (values above DEPTH disable the flag)
//   out_data    - head-of-FIFO byte, 0 while empty
//   out_valid   - FIFO non-empty
//   out_ready   - consumer accepts out_data
//   count       - occupancy, 0..DEPTH
//   full        - count == DEPTH
//   almost_full - count >= af_level
//   overflow    - sticky, set when an incoming byte was dropped
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  data_valid,
  input  logic                  flush,
  input  logic                  clr_ovf,
  input  logic [ADDR_WIDTH:0]   af_level,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow
);

  if (DEPTH != (1 << ADDR_WIDTH)) begin : g_depth_check
    $error("uart_rx_fifo: DEPTH must equal 2**ADDR_WIDTH");
  end

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] PTR_ONE   = (ADDR_WIDTH + 1)'(1);

  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  push;
  logic                  pop;
  logic                  accept;
  logic                  drop;

  assign out_valid   = (count != '0);
  assign full        = (count == DEPTH_CNT);
  assign almost_full = (count >= af_level);
  assign out_data    = out_valid ? rdata : '0;

  assign push   = data_valid & ~flush;
  assign pop    = out_valid & out_ready & ~flush;
  // When full, a same-cycle pop frees the slot the push writes into; the
  // write address then equals the read address, and the read sees the old
  // head because the write only lands on the edge.
  assign accept = push & (~full | pop);
  assign drop   = push & ~accept;

  uart_rx_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (CLK),
    .we    (accept & ~RST),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (P_DATA),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (rdata)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      // count tracks wr_ptr - rd_ptr without a subtractor on the output path
      unique case ({accept, pop})
        2'b10:   count <= count + PTR_ONE;
        2'b01:   count <= count - PTR_ONE;
        default: count <= count;
      endcase
    end
  end

  // Set takes precedence over clear; flush has no effect here because it
  // suppresses push, so it can never produce a drop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a queue-based reference model checked
// every cycle, plus directed scenarios with literal expected values.
module tb_uart_rx_fifo;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DP = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] P_DATA;
  logic          data_valid;
  logic          flush;
  logic          clr_ovf;
  logic [AW:0]   af_level;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW:0]   count;
  logic          full;
  logic          almost_full;
  logic          overflow;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  uart_rx_fifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DP)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .P_DATA      (P_DATA),
    .data_valid  (data_valid),
    .flush       (flush),
    .clr_ovf     (clr_ovf),
    .af_level    (af_level),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .count       (count),
    .full        (full),
    .almost_full (almost_full),
    .overflow    (overflow)
  );

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: the FIFO is a queue of bytes plus a sticky flag.
  logic [DW-1:0] mq[$];
  bit            m_ovf = 1'b0;
  bit            chk_en = 1'b0;

  always @(posedge CLK) begin
    bit popping;
    bit dropped;
    dropped = 1'b0;
    if (RST) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      if (flush) begin
        mq.delete();
      end else begin
        popping = (mq.size() > 0) && out_ready;
        if (data_valid && !(mq.size() < DP || popping)) dropped = 1'b1;
        if (popping) void'(mq.pop_front());
        if (data_valid && !dropped) mq.push_back(P_DATA);
      end
      if (dropped) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("mdl_out_valid", int'(out_valid), int'(mq.size() != 0));
      check("mdl_out_data", int'(out_data), (mq.size() != 0) ? int'(mq[0]) : 0);
      check("mdl_count", int'(count), mq.size());
      check("mdl_full", int'(full), int'(mq.size() == DP));
      check("mdl_almost_full", int'(almost_full), int'(mq.size() >= int'(af_level)));
      check("mdl_overflow", int'(overflow), int'(m_ovf));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] b);
    P_DATA     = b;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; P_DATA = '0; data_valid = 1'b0; flush = 1'b0;
    clr_ovf = 1'b0; af_level = 5'd16; out_ready = 1'b0;
    tick(); tick();
    RST = 1'b0;
    chk_en = 1'b1;
    check("rst_count", int'(count), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_full", int'(full), 0);
    check("rst_overflow", int'(overflow), 0);

    // 1: single byte latency and pop
    push(8'hA5);
    check("t1_valid", int'(out_valid), 1);
    check("t1_data", int'(out_data), 'hA5);
    check("t1_count", int'(count), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t1_pop_valid", int'(out_valid), 0);
    check("t1_pop_count", int'(count), 0);
    check("t1_pop_data", int'(out_data), 0);

    // 2: fill, overflow drop, drain in order
    for (int i = 0; i < 16; i++) push(8'(i));
    check("t2_count", int'(count), 16);
    check("t2_full", int'(full), 1);
    push(8'h55);
    check("t2_ovf", int'(overflow), 1);
    check("t2_count_hold", int'(count), 16);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("t2_drain", int'(out_data), i);
      tick();
    end
    out_ready = 1'b0;
    check("t2_empty", int'(count), 0);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("t2_clr", int'(overflow), 0);

    // 3: push while full with a concurrent pop is accepted
    for (int i = 0; i < 16; i++) push(8'(16 + i));
    out_ready = 1'b1;
    push(8'h77);
    check("t3_ovf", int'(overflow), 0);
    check("t3_count", int'(count), 16);
    for (int i = 0; i < 16; i++) begin
      if (i == 0) check("t3_first", int'(out_data), 'h11);
      if (i == 15) check("t3_last", int'(out_data), 'h77);
      tick();
    end
    out_ready = 1'b0;
    check("t3_empty", int'(count), 0);

    // 4: streaming push+pop for 40 bytes
    out_ready = 1'b1;
    push(8'h80);
    for (int i = 1; i < 40; i++) begin
      check("t4_data", int'(out_data), 'h80 + i - 1);
      P_DATA = 8'('h80 + i);
      data_valid = 1'b1;
      tick();
      check("t4_count", int'(count), 1);
    end
    data_valid = 1'b0;
    check("t4_tail", int'(out_data), 'hA7);
    tick();
    out_ready = 1'b0;
    check("t4_empty", int'(count), 0);

    // 5: almost_full threshold and flush with concurrent push
    af_level = 5'd12;
    for (int i = 0; i < 11; i++) push(8'(i + 'h40));
    check("t5_af_11", int'(almost_full), 0);
    push(8'h4B);
    check("t5_af_12", int'(almost_full), 1);
    flush = 1'b1; P_DATA = 8'h99; data_valid = 1'b1;
    tick();
    flush = 1'b0; data_valid = 1'b0;
    check("t5_flush_count", int'(count), 0);
    check("t5_flush_valid", int'(out_valid), 0);
    check("t5_flush_ovf", int'(overflow), 0);

    // 6: af_level beyond DEPTH, overflow set/clear priority, reset mid-drain
    af_level = 5'd17;
    for (int i = 0; i < 16; i++) push(8'(i + 'h60));
    check("t6_af_off", int'(almost_full), 0);
    push(8'hEE);
    check("t6_ovf_set", int'(overflow), 1);
    clr_ovf = 1'b1; P_DATA = 8'hEF; data_valid = 1'b1;
    tick();
    clr_ovf = 1'b0; data_valid = 1'b0;
    check("t6_set_wins", int'(overflow), 1);
    flush = 1'b1; tick(); flush = 1'b0;
    check("t6_flush_keeps_ovf", int'(overflow), 1);
    check("t6_flush_count", int'(count), 0);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("t6_clr", int'(overflow), 0);
    for (int i = 0; i < 8; i++) push(8'(i + 'hC0));
    out_ready = 1'b1;
    tick(); tick(); tick();
    check("t6_mid_count", int'(count), 5);
    check("t6_mid_data", int'(out_data), 'hC3);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    out_ready = 1'b0;
    check("t6_rst_count", int'(count), 0);
    check("t6_rst_valid", int'(out_valid), 0);
    af_level = 5'd0;
    #1;
    check("t6_af_zero", int'(almost_full), 1);
    tick(); tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
